zframe_reader: RTL and testbench

//  Display-side reader of the SDRAM frame buffer filled by the draw path. Issues single-word

---
 rtl/zframe_reader.sv | 178 +++++++++++++++++
 tb/tb_zframe_reader.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zframe_reader.sv
// SDRAM frame-buffer reader: prefetches RGB565 words into a small FIFO and hands one pixel per TFT request.
// Optional build macro ZFRAME_READER_DOUBLE_BUFFER_EN adds iBuf_Sel to pick one of two frame bases.
module zframe_reader #(
  parameter int          H_ACTIVE      = 480,
  parameter int          V_ACTIVE      = 272,
  parameter logic [23:0] FRAME_BASE    = 24'h0,
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [15:0] UNDERFLOW_RGB = 16'hF800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        iFrame_Start,
  input  logic        iPixel_Req,
`ifdef ZFRAME_READER_DOUBLE_BUFFER_EN
  input  logic        iBuf_Sel,
`endif
  output logic [15:0] oPixel_Data,
  output logic        oPixel_Valid,
  output logic        oUnderflow,
  output logic [23:0] oSDRAM_Rd_Addr,
  output logic        oSDRAM_Rd_Req,
  input  logic        iSDRAM_Rd_Done,
  input  logic [15:0] iSDRAM_Rd_Data
);

  localparam int TOTAL  = H_ACTIVE * V_ACTIVE;
  localparam int FC_REQ = $clog2(TOTAL + 1);
  localparam int FC_W   = (FC_REQ > 17) ? FC_REQ : 17;
  localparam int AW     = $clog2(FIFO_DEPTH);

  localparam logic [FC_W-1:0] FC_TOTAL      = FC_W'(TOTAL);
  localparam logic [AW:0]     CNT_ISSUE_MAX = (AW + 1)'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_HOLD,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_drop;
  logic            w_drop_nxt;
  logic [FC_W-1:0] r_fetch_cnt;
  logic [FC_W-1:0] w_fetch_nxt;
  logic [23:0]     r_base;
  logic [23:0]     w_base_sel;
  logic [23:0]     w_base_nxt;
  logic            r_rd_req;
  logic [23:0]     r_rd_addr;

  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            w_empty;
  logic            w_pix_req;
  logic            w_pop;
  logic            w_push;
  logic            w_can_issue;

  logic [15:0]     r_pix_data_p1;
  logic            r_pix_vld_p1;
  logic            r_underflow;

`ifdef ZFRAME_READER_DOUBLE_BUFFER_EN
  assign w_base_sel = iBuf_Sel ? (FRAME_BASE + 24'h020000) : FRAME_BASE;
`else
  assign w_base_sel = FRAME_BASE;
`endif

  // The base is sampled only at frame start so a mid-frame buffer toggle cannot split a frame.
  assign w_base_nxt  = iFrame_Start ? w_base_sel : r_base;

  assign w_empty     = (r_count == '0);
  assign w_pix_req   = iPixel_Req & ~iFrame_Start;
  assign w_pop       = w_pix_req & ~w_empty;
  assign w_push      = (r_state == S_REQ) & iSDRAM_Rd_Done & ~r_drop & ~iFrame_Start;
  assign w_fetch_nxt = iFrame_Start ? '0 : (w_push ? r_fetch_cnt + 1'b1 : r_fetch_cnt);
  assign w_can_issue = en & (r_fetch_cnt < FC_TOTAL) & (r_count <= CNT_ISSUE_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    case (r_state)
      S_IDLE: if (en && iFrame_Start) w_state_nxt = S_REQ;
      S_REQ: begin
        if (iSDRAM_Rd_Done) begin
          w_state_nxt = S_GAP;
          w_drop_nxt  = 1'b0;
        end
      end
      S_GAP:  w_state_nxt = w_can_issue ? S_REQ : S_HOLD;
      S_HOLD: begin
        if (r_fetch_cnt == FC_TOTAL) w_state_nxt = S_DONE;
        else if (w_can_issue)        w_state_nxt = S_REQ;
      end
      S_DONE: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A read in flight must finish on the bus; its word is thrown away and fetching restarts afterwards.
    if (iFrame_Start && (r_state != S_IDLE)) begin
      if (r_state == S_REQ) begin
        if (!iSDRAM_Rd_Done) w_drop_nxt = 1'b1;
      end else begin
        w_state_nxt = en ? S_REQ : S_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_drop      <= 1'b0;
      r_fetch_cnt <= '0;
      r_base      <= FRAME_BASE;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drop      <= w_drop_nxt;
      r_fetch_cnt <= w_fetch_nxt;
      r_base      <= w_base_nxt;
      r_rd_req    <= (w_state_nxt == S_REQ);
      if ((w_state_nxt == S_REQ) && (r_state != S_REQ))
        r_rd_addr <= w_base_nxt + 24'(w_fetch_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= iSDRAM_Rd_Data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (iFrame_Start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---- stage p1: pixel handed to the TFT one cycle after its request ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_data_p1 <= '0;
      r_pix_vld_p1  <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_pix_vld_p1 <= w_pix_req;
      if (w_pix_req) r_pix_data_p1 <= w_empty ? UNDERFLOW_RGB : r_mem[r_rd_ptr];
      if (iFrame_Start)            r_underflow <= 1'b0;
      else if (w_pix_req && w_empty) r_underflow <= 1'b1;
    end
  end

  assign oPixel_Data    = r_pix_data_p1;
  assign oPixel_Valid   = r_pix_vld_p1;
  assign oUnderflow     = r_underflow;
  assign oSDRAM_Rd_Addr = r_rd_addr;
  assign oSDRAM_Rd_Req  = r_rd_req;

endmodule

// File: tb/tb_zframe_reader.sv
// Self-checking bench for zframe_reader: latency-configurable SDRAM model plus a pixel-queue reference model.
`timescale 1ns/1ps
module tb_zframe_reader;

  localparam int          H      = 8;
  localparam int          V      = 4;
  localparam int          N      = H * V;
  localparam int          DEPTH  = 16;
  localparam logic [15:0] UF_RGB = 16'hF800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_req = 1'b0;
  logic        buf_sel = 1'b0;
  logic        sd_done = 1'b0;
  logic [15:0] sd_data = '0;
  logic [15:0] pix_data;
  logic        pix_vld;
  logic        underflow;
  logic [23:0] rd_addr;
  logic        rd_req;

  int checks = 0;
  int errors = 0;
  int sd_lat = 3;
  int sd_cnt = 0;
  int proto_viol = 0;
  int mdl_max = 0;
  bit mdl_drop = 1'b0;
  bit mdl_uf = 1'b0;
  bit prev_req = 1'b0;
  logic [23:0] prev_addr = '0;

  logic [15:0] mdl_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [23:0] addr_log[$];

  zframe_reader #(
    .H_ACTIVE(H), .V_ACTIVE(V), .FRAME_BASE(24'h0), .FIFO_DEPTH(DEPTH), .UNDERFLOW_RGB(UF_RGB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .iFrame_Start(frame_start),
    .iPixel_Req(pixel_req),
`ifdef ZFRAME_READER_DOUBLE_BUFFER_EN
    .iBuf_Sel(buf_sel),
`endif
    .oPixel_Data(pix_data),
    .oPixel_Valid(pix_vld),
    .oUnderflow(underflow),
    .oSDRAM_Rd_Addr(rd_addr),
    .oSDRAM_Rd_Req(rd_req),
    .iSDRAM_Rd_Done(sd_done),
    .iSDRAM_Rd_Data(sd_data)
  );

  always #5 clk = ~clk;

  // SDRAM read port: answers a held request after sd_lat cycles with the low half of its address
  always @(negedge clk) begin
    if (!rst_n) begin
      sd_done = 1'b0;
      sd_cnt  = 0;
    end else if (sd_done) begin
      sd_done = 1'b0;
    end else if (rd_req) begin
      sd_cnt++;
      if (sd_cnt >= sd_lat) begin
        sd_done = 1'b1;
        sd_data = rd_addr[15:0];
        sd_cnt  = 0;
      end
    end else begin
      sd_cnt = 0;
    end
  end

  // Reference model: queue of delivered words; a request pops the oldest word or gets the underflow colour
  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_q.delete();
      mdl_drop = 1'b0;
      mdl_uf   = 1'b0;
    end else if (frame_start) begin
      mdl_q.delete();
      mdl_uf   = 1'b0;
      mdl_drop = rd_req && !sd_done;
    end else begin
      if (pixel_req) begin
        if (mdl_q.size() > 0) exp_q.push_back(mdl_q.pop_front());
        else begin
          exp_q.push_back(UF_RGB);
          mdl_uf = 1'b1;
        end
      end
      if (sd_done) begin
        if (mdl_drop) mdl_drop = 1'b0;
        else mdl_q.push_back(sd_data);
      end
      if (mdl_q.size() > mdl_max) mdl_max = mdl_q.size();
    end
  end

  // Monitor: logs issued addresses, returned pixels and bus-protocol violations
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (rd_req && !prev_req) addr_log.push_back(rd_addr);
      if (prev_req && !rd_req && !sd_done) proto_viol++;
      if (prev_req && rd_req && (rd_addr != prev_addr)) proto_viol++;
      if (pix_vld) got_q.push_back(pix_data);
    end
    prev_req  = rd_req;
    prev_addr = rd_addr;
  end

  task automatic clear_logs();
    addr_log.delete();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_pixel();
    pixel_req = 1'b1;
    @(negedge clk);
    pixel_req = 1'b0;
  endtask

  task automatic wait_req_addr(input logic [23:0] a, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd_req && (rd_addr == a)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", rd_req); end
    checks++; if (rd_addr !== 24'h0) begin errors++; $display("FAIL reset_addr got=%h want=000000", rd_addr); end
    checks++; if (pix_vld !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", pix_vld); end
    checks++; if (pix_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h want=0000", pix_data); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b want=0", underflow); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle();
    clear_logs();
    en = 1'b0;
    pulse_frame();
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (addr_log.size() != 0) begin errors++; $display("FAIL idle_no_read got=%0d want=0", addr_log.size()); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b want=0", rd_req); end
  endtask

  task automatic test_frame_fill();
    int waited;
    sd_lat = 3;
    en = 1'b1;
    clear_logs();
    pulse_frame();
    for (int k = 0; k < N; k++) begin
      waited = 0;
      while (mdl_q.size() == 0 && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 100) begin
        checks++; errors++;
        $display("FAIL fill_timeout got=no_word want=word_%0d", k);
        break;
      end
      pulse_pixel();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    checks++; if (addr_log.size() != N) begin errors++; $display("FAIL fill_read_count got=%0d want=%0d", addr_log.size(), N); end
    for (int k = 0; k < addr_log.size(); k++) begin
      checks++; if (addr_log[k] !== 24'(k)) begin errors++; $display("FAIL fill_addr[%0d] got=%h want=%h", k, addr_log[k], 24'(k)); end
    end
    checks++; if (got_q.size() != N) begin errors++; $display("FAIL fill_pixel_count got=%0d want=%0d", got_q.size(), N); end
    for (int k = 0; k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== 16'(k)) begin errors++; $display("FAIL fill_pixel[%0d] got=%h want=%h", k, got_q[k], 16'(k)); end
    end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL fill_underflow got=%b want=0", underflow); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL fill_done_req got=%b want=0", rd_req); end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL fill_protocol got=%0d want=0", proto_viol); end
  endtask

  task automatic test_underflow();
    sd_lat = 5;
    clear_logs();
    pulse_frame();
    pixel_req = 1'b1;
    repeat (N) @(negedge clk);
    pixel_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (got_q.size() != N) begin errors++; $display("FAIL uf_count got=%0d want=%0d", got_q.size(), N); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL uf_pixel[%0d] got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== UF_RGB) begin errors++; $display("FAIL uf_first got=%h want=%h", got_q[0], UF_RGB); end
    end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%b want=1", underflow); end
    pulse_frame();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b want=0", underflow); end
  endtask

  task automatic test_fifo_full();
    sd_lat = $urandom_range(1, 4);
    clear_logs();
    pulse_frame();
    repeat (200) @(negedge clk);
    checks++; if (addr_log.size() != DEPTH) begin errors++; $display("FAIL full_reads got=%0d want=%0d", addr_log.size(), DEPTH); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL full_req got=%b want=0", rd_req); end
    checks++; if (mdl_max > DEPTH) begin errors++; $display("FAIL full_occupancy got=%0d want<=%0d", mdl_max, DEPTH); end
    pulse_pixel();
    repeat (60) @(negedge clk);
    checks++; if (addr_log.size() != DEPTH + 1) begin errors++; $display("FAIL full_refill got=%0d want=%0d", addr_log.size(), DEPTH + 1); end
    if (addr_log.size() > DEPTH) begin
      checks++; if (addr_log[DEPTH] !== 24'(DEPTH)) begin errors++; $display("FAIL full_refill_addr got=%h want=%h", addr_log[DEPTH], 24'(DEPTH)); end
    end
    checks++; if (got_q.size() != 1 || got_q[0] !== 16'h0) begin errors++; $display("FAIL full_pop got_n=%0d want_n=1 want=0000", got_q.size()); end
  endtask

  task automatic test_restart();
    bit ok;
    sd_lat = 6;
    pulse_frame();
    wait_req_addr(24'd5, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_reach got=timeout want=addr_5"); end
    clear_logs();
    frame_start = 1'b1;
    pixel_req = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    pixel_req = 1'b0;
    checks++; if (rd_req !== 1'b1 || rd_addr !== 24'd5) begin errors++; $display("FAIL restart_hold got=%b/%h want=1/000005", rd_req, rd_addr); end
    repeat (30) @(negedge clk);
    checks++; if (addr_log.size() < 1 || addr_log[0] !== 24'h0) begin errors++; $display("FAIL restart_addr got_n=%0d want first=000000", addr_log.size()); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL restart_ignored_pixel got=%0d want=0", got_q.size()); end
    pulse_pixel();
    @(negedge clk);
    checks++; if (got_q.size() != 1 || got_q[0] !== 16'h0) begin errors++; $display("FAIL restart_first_pixel got_n=%0d want=0000", got_q.size()); end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL restart_protocol got=%0d want=0", proto_viol); end
  endtask

  task automatic test_enable();
    bit ok;
    sd_lat = 4;
    clear_logs();
    pulse_frame();
    wait_req_addr(24'd7, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_reach got=timeout want=addr_7"); end
    en = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (addr_log.size() != 8) begin errors++; $display("FAIL en_stop got=%0d want=8", addr_log.size()); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL en_req got=%b want=0", rd_req); end
    pulse_pixel();
    @(negedge clk);
    checks++; if (got_q.size() != 1 || got_q[0] !== 16'h0) begin errors++; $display("FAIL en_pop got_n=%0d want=0000", got_q.size()); end
    en = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (addr_log.size() < 9 || addr_log[8] !== 24'd8) begin errors++; $display("FAIL en_resume got_n=%0d want addr=000008", addr_log.size()); end
  endtask

  task automatic test_back_to_back();
    int prob;
    int len;
    en = 1'b1;
    clear_logs();
    for (int f = 0; f < 4; f++) begin
      sd_lat = $urandom_range(1, 6);
      prob = $urandom_range(10, 90);
      len = $urandom_range(20, 150);
      frame_start = 1'b1;
      pixel_req = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      frame_start = 1'b0;
      for (int c = 0; c < len; c++) begin
        pixel_req = ($urandom_range(0, 99) < prob);
        @(negedge clk);
      end
      pixel_req = 1'b0;
    end
    repeat (5) @(negedge clk);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_pixel[%0d] got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (underflow !== mdl_uf) begin errors++; $display("FAIL rand_underflow got=%b want=%b", underflow, mdl_uf); end
    checks++; if (mdl_max > DEPTH) begin errors++; $display("FAIL rand_occupancy got=%0d want<=%0d", mdl_max, DEPTH); end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL rand_protocol got=%0d want=0", proto_viol); end
  endtask

`ifdef ZFRAME_READER_DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    sd_lat = 2;
    buf_sel = 1'b1;
    clear_logs();
    pulse_frame();
    repeat (3) @(negedge clk);
    buf_sel = 1'b0;
    repeat (60) @(negedge clk);
    checks++; if (addr_log.size() < 4 || addr_log[0] !== 24'h020000) begin errors++; $display("FAIL dbuf_first got_n=%0d want=020000", addr_log.size()); end
    if (addr_log.size() >= 4) begin
      checks++; if (addr_log[3] !== 24'h020003) begin errors++; $display("FAIL dbuf_hold got=%h want=020003", addr_log[3]); end
    end
    clear_logs();
    pulse_frame();
    repeat (20) @(negedge clk);
    checks++; if (addr_log.size() < 1 || addr_log[0] !== 24'h0) begin errors++; $display("FAIL dbuf_sel0 got_n=%0d want=000000", addr_log.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_frame_fill();
    test_underflow();
    test_fifo_full();
    test_restart();
    test_enable();
    test_back_to_back();
`ifdef ZFRAME_READER_DOUBLE_BUFFER_EN
    test_double_buffer();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
